// File: rtl/lcd_writer_if.sv
// +----------------------------------------------------------------------+
// | lcd_writer_if : byte write handshake into the character LCD writer    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface lcd_writer_if;
  logic       i_valid;
  logic       i_rs;
  logic [7:0] i_data;
  logic       o_ready;

  modport master (output i_valid, output i_rs, output i_data, input o_ready);
  modport slave  (input i_valid, input i_rs, input i_data, output o_ready);
endinterface

`default_nettype wire

// File: rtl/lcd_writer.sv
// +----------------------------------------------------------------------+
// | lcd_writer : write-only HD44780 16x2 LCD controller (RS/DATA/EN)      |
// | Optional macro LCD_AUTO_INIT_EN: issue 38/0C/01/06 after power-up.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module lcd_writer #(
  parameter int unsigned PWR_WAIT_CYC = 750000,
  parameter int unsigned EN_CYC       = 25,
  parameter int unsigned CMD_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  wire logic       i_clk,
  input  wire logic       i_rst_n,
  lcd_writer_if.slave     bus,
  output logic            o_init_done,
  output logic [7:0]      o_lcd_data,
  output logic            o_lcd_rs,
  output logic            o_lcd_rw,
  output logic            o_lcd_en,
  output logic            o_lcd_on
);

  localparam int unsigned c_m1 = (PWR_WAIT_CYC > CLR_WAIT_CYC) ? PWR_WAIT_CYC : CLR_WAIT_CYC;
  localparam int unsigned c_m2 = (CMD_WAIT_CYC > EN_CYC) ? CMD_WAIT_CYC : EN_CYC;
  localparam int unsigned c_cnt_max = (c_m1 > c_m2) ? c_m1 : c_m2;
  localparam int unsigned c_cnt_w = $clog2(c_cnt_max + 1);

  typedef enum logic [2:0] {
    PWR_WAIT   = 3'd0,
    INIT_ISSUE = 3'd1,
    IDLE       = 3'd2,
    SETUP      = 3'd3,
    PULSE      = 3'd4,
    HOLD       = 3'd5,
    EXEC       = 3'd6
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_lim;
  logic                 w_done;
  logic                 w_clr;
  logic [1:0]           r_init_idx;
  logic [7:0]           w_init_byte;
  logic                 r_ready;
  logic                 r_init_done;
  logic [7:0]           r_lcd_data;
  logic                 r_lcd_rs;
  logic                 r_lcd_en;
  logic                 r_lcd_on;

  // Clear (0x01) and home (0x02/0x03) need the long execution wait
  assign w_clr = !r_lcd_rs && (r_lcd_data[7:2] == 6'd0) && (r_lcd_data != 8'd0);

  always_comb begin
    w_lim = '0;
    case (r_state)
      PWR_WAIT: w_lim = c_cnt_w'(PWR_WAIT_CYC);
      SETUP:    w_lim = c_cnt_w'(1);
      PULSE:    w_lim = c_cnt_w'(EN_CYC - 1);
      HOLD:     w_lim = c_cnt_w'(1);
      EXEC:     w_lim = w_clr ? c_cnt_w'(CLR_WAIT_CYC - 1) : c_cnt_w'(CMD_WAIT_CYC - 1);
      default:  w_lim = '0;
    endcase
  end

  assign w_done = (r_cnt == w_lim);

  always_comb begin
    w_init_byte = 8'h38;
    case (r_init_idx)
      2'd0: w_init_byte = 8'h38;
      2'd1: w_init_byte = 8'h0C;
      2'd2: w_init_byte = 8'h01;
      2'd3: w_init_byte = 8'h06;
      default: w_init_byte = 8'h38;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= PWR_WAIT;
      r_cnt       <= '0;
      r_init_idx  <= 2'd0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_lcd_data  <= 8'd0;
      r_lcd_rs    <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_lcd_on    <= 1'b0;
    end else begin
      r_lcd_on <= 1'b1;
      // Every state transition happens on w_done, so the counter restarts at 0 on entry
      r_cnt    <= w_done ? '0 : r_cnt + 1'b1;
      case (r_state)
        PWR_WAIT: begin
          if (w_done) begin
`ifdef LCD_AUTO_INIT_EN
            r_state    <= INIT_ISSUE;
            r_init_idx <= 2'd0;
`else
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_init_done <= 1'b1;
`endif
          end
        end
        INIT_ISSUE: begin
          r_lcd_rs   <= 1'b0;
          r_lcd_data <= w_init_byte;
          r_state    <= SETUP;
        end
        IDLE: begin
          if (bus.i_valid && r_ready) begin
            r_lcd_rs   <= bus.i_rs;
            r_lcd_data <= bus.i_data;
            r_ready    <= 1'b0;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          if (w_done) begin
            r_lcd_en <= 1'b1;
            r_state  <= PULSE;
          end
        end
        PULSE: begin
          if (w_done) begin
            r_lcd_en <= 1'b0;
            r_state  <= HOLD;
          end
        end
        HOLD: begin
          if (w_done) r_state <= EXEC;
        end
        EXEC: begin
          if (w_done) begin
            if (r_init_done || r_init_idx == 2'd3) begin
              r_state     <= IDLE;
              r_ready     <= 1'b1;
              r_init_done <= 1'b1;
            end else begin
              r_init_idx <= r_init_idx + 2'd1;
              r_state    <= INIT_ISSUE;
            end
          end
        end
        default: begin
          r_state <= PWR_WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.o_ready  = r_ready;
  assign o_init_done  = r_init_done;
  assign o_lcd_data   = r_lcd_data;
  assign o_lcd_rs     = r_lcd_rs;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_en     = r_lcd_en;
  assign o_lcd_on     = r_lcd_on;

endmodule

`default_nettype wire

// File: tb/tb_lcd_writer.sv
// +----------------------------------------------------------------------+
// | tb_lcd_writer : directed self-checking bench for lcd_writer           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lcd_writer;

  localparam int unsigned PWR = 10;
  localparam int unsigned EN  = 3;
  localparam int unsigned CMD = 5;
  localparam int unsigned CLR = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_done;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  logic [8:0] plog [0:63];
  logic       prev_en = 1'b0;

  lcd_writer_if bus ();

  lcd_writer #(
    .PWR_WAIT_CYC (PWR),
    .EN_CYC       (EN),
    .CMD_WAIT_CYC (CMD),
    .CLR_WAIT_CYC (CLR)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_init_done (init_done),
    .o_lcd_data  (lcd_data),
    .o_lcd_rs    (lcd_rs),
    .o_lcd_rw    (lcd_rw),
    .o_lcd_en    (lcd_en),
    .o_lcd_on    (lcd_on)
  );

  always #5 clk = ~clk;

  // Log the data/rs carried by every enable pulse
  always @(negedge clk) begin
    if (lcd_en === 1'b1 && prev_en !== 1'b1) begin
      if (n_pulses < 64) plog[n_pulses] = {lcd_rs, lcd_data};
      n_pulses = n_pulses + 1;
    end
    prev_en = lcd_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic release_and_wait();
    int base;
    base = n_pulses;
    rst_n = 1'b1;
    chk("pre-release ready", bus.o_ready, 0);
    chk("pre-release lcd_on", lcd_on, 0);
    for (int k = 1; k <= PWR; k++) begin
      tick();
      chk("pwr ready", bus.o_ready, 0);
      chk("pwr init_done", init_done, 0);
      chk("pwr lcd_on", lcd_on, 1);
    end
`ifdef LCD_AUTO_INIT_EN
    bus.i_valid = 1'b1;
    bus.i_rs    = 1'b1;
    bus.i_data  = 8'hAA;
    tick();
    for (int c = 0; c < 300 && bus.o_ready !== 1'b1; c++) begin
      chk("init done_vs_ready", init_done, bus.o_ready);
      tick();
    end
    bus.i_valid = 1'b0;
    chk("init ready", bus.o_ready, 1);
    chk("init init_done", init_done, 1);
    chk("init pulse count", n_pulses - base, 4);
    chk("init byte0", plog[base],   9'h038);
    chk("init byte1", plog[base+1], 9'h00C);
    chk("init byte2", plog[base+2], 9'h001);
    chk("init byte3", plog[base+3], 9'h006);
`else
    tick();
    chk("pwr end ready", bus.o_ready, 1);
    chk("pwr end init_done", init_done, 1);
    chk("pwr no pulses", n_pulses - base, 0);
`endif
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d, input int ret, input string tag);
    int base;
    base = n_pulses;
    chk({tag, " ready before"}, bus.o_ready, 1);
    bus.i_valid = 1'b1;
    bus.i_rs    = rs;
    bus.i_data  = d;
    tick();
    bus.i_valid = 1'b0;
    for (int k = 1; k <= ret; k++) begin
      chk({tag, " en"}, lcd_en, (k >= 3 && k <= 2 + EN) ? 1 : 0);
      chk({tag, " ready"}, bus.o_ready, (k == ret) ? 1 : 0);
      if (k == 1 || k == ret) begin
        chk({tag, " data"}, lcd_data, d);
        chk({tag, " rs"}, lcd_rs, rs);
      end
      if (k < ret) tick();
    end
    chk({tag, " one pulse"}, n_pulses - base, 1);
  endtask

  initial begin
    int p0;
    bus.i_valid = 1'b0;
    bus.i_rs    = 1'b0;
    bus.i_data  = 8'h00;
    rst_n       = 1'b0;
    repeat (3) tick();

    chk("reset ready", bus.o_ready, 0);
    chk("reset init_done", init_done, 0);
    chk("reset data", lcd_data, 0);
    chk("reset rs", lcd_rs, 0);
    chk("reset en", lcd_en, 0);
    chk("reset on", lcd_on, 0);
    chk("reset rw", lcd_rw, 0);

    release_and_wait();

    do_write(1'b1, 8'h41, 8 + CMD, "wr41");
    do_write(1'b0, 8'h01, 8 + CLR, "clr01");
    do_write(1'b0, 8'h02, 8 + CLR, "home02");
    do_write(1'b0, 8'h03, 8 + CLR, "home03");
    do_write(1'b0, 8'h04, 8 + CMD, "cmd04");
    do_write(1'b1, 8'h01, 8 + CMD, "chr01");
    do_write(1'b0, 8'h00, 8 + CMD, "cmd00");
    chk("rw low", lcd_rw, 0);

    // Back-to-back request held high across the busy window
    p0 = n_pulses;
    bus.i_valid = 1'b1;
    bus.i_rs    = 1'b1;
    bus.i_data  = 8'h41;
    tick();
    bus.i_data  = 8'h42;
    for (int k = 1; k <= 12; k++) begin
      chk("b2b busy ready", bus.o_ready, 0);
      tick();
    end
    chk("b2b ready at T+13", bus.o_ready, 1);
    chk("b2b data held", lcd_data, 8'h41);
    chk("b2b first pulse", n_pulses - p0, 1);
    tick();
    bus.i_valid = 1'b0;
    chk("b2b second accept ready", bus.o_ready, 0);
    chk("b2b second data", lcd_data, 8'h42);
    repeat (12) tick();
    chk("b2b second ready", bus.o_ready, 1);
    chk("b2b pulse total", n_pulses - p0, 2);
    chk("b2b pulse0", plog[p0], 9'h141);
    chk("b2b pulse1", plog[p0+1], 9'h142);

    // Reset during the enable pulse
    bus.i_valid = 1'b1;
    bus.i_rs    = 1'b1;
    bus.i_data  = 8'h43;
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();
    chk("abort en in pulse", lcd_en, 1);
    rst_n = 1'b0;
    tick();
    chk("abort en", lcd_en, 0);
    chk("abort ready", bus.o_ready, 0);
    chk("abort data", lcd_data, 0);
    chk("abort rs", lcd_rs, 0);
    chk("abort on", lcd_on, 0);
    chk("abort init_done", init_done, 0);
    tick();
    release_and_wait();
    do_write(1'b1, 8'h5A, 8 + CMD, "post-abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lcd_writer.md
Name: lcd_writer

Overview:
- Write-only HD44780-compatible character LCD controller for the DE2 board's 16x2 LCD. It is the output-side counterpart to the debounced button/switch inputs.
- Accepts command or character bytes from an IO-mapped source over a valid/ready handshake.
- Generates the LCD_RS/LCD_DATA/LCD_EN timing, then waits out each instruction's execution time.
- Runs a power-up wait, plus an optional init sequence, before accepting traffic.

Parameters:
- PWR_WAIT_CYC, 750000: power-up wait in clock cycles (15 ms at 50 MHz).
- EN_CYC, 25: LCD_EN high time in cycles (500 ns); minimum 1.
- CMD_WAIT_CYC, 2000: post-write execution wait for normal commands and data (40 us).
- CLR_WAIT_CYC, 82000: post-write execution wait for clear/home commands (1.64 ms).

Ports:
- i_clk, input, 1: system clock, 50 MHz.
- i_rst_n, input, 1: synchronous active-low reset.
- i_valid, input, 1: write request.
- i_rs, input, 1: 0 = instruction, 1 = data (character).
- i_data, input, 8: byte to write.
- o_ready, output, 1: writer idle; a request is accepted when i_valid && o_ready.
- o_init_done, output, 1: power-up wait and init are complete; stays 1 until reset.
- o_lcd_data, output, 8: LCD data bus.
- o_lcd_rs, output, 1: LCD register select.
- o_lcd_rw, output, 1: LCD read/write; tied to 0 (write only).
- o_lcd_en, output, 1: LCD enable strobe.
- o_lcd_on, output, 1: LCD power enable.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is synchronous, active-low.
- Reset values (while i_rst_n = 0): all outputs 0, state PWR_WAIT, counter 0.
  - Reset asserted mid-transfer aborts immediately: o_lcd_en drops to 0 on the next edge and the power-up wait restarts.
- o_lcd_on: 1 from the first cycle after reset is released.
- o_lcd_rw: always 0.
- All outputs are registered.
- FSM states: PWR_WAIT, INIT_ISSUE, IDLE, SETUP, PULSE, HOLD, EXEC.
- PWR_WAIT: counts PWR_WAIT_CYC cycles. Then:
  - goes to INIT_ISSUE if LCD_AUTO_INIT_EN is defined;
  - otherwise goes to IDLE and sets o_init_done.
- INIT_ISSUE: internally issues rs=0 bytes 0x38, 0x0C, 0x01, 0x06, in order.
  - Each byte goes through SETUP/PULSE/HOLD/EXEC exactly like an external write.
  - After the EXEC of 0x06: go to IDLE and set o_init_done.
  - o_ready stays 0 throughout.
- IDLE: o_ready = 1.
  - On i_valid && o_ready at edge T: latch i_rs and i_data into o_lcd_rs and o_lcd_data, drop o_ready, go to SETUP.
  - i_valid is ignored whenever o_ready = 0. Requests are neither queued nor acknowledged.
- Transfer timing, with acceptance at edge T:
  - SETUP: cycles T+1 to T+2, o_lcd_en = 0, data/rs stable.
  - PULSE: cycles T+3 to T+2+EN_CYC, o_lcd_en = 1.
  - HOLD: 2 cycles, o_lcd_en = 0, data/rs still held.
  - EXEC: W cycles, where W is chosen as follows:
    - W = CLR_WAIT_CYC if rs = 0 and data[7:2] = 0 and data != 0 (clear 0x01, home 0x02/0x03);
    - W = CMD_WAIT_CYC otherwise.
  - o_ready returns to 1 in cycle T+5+EN_CYC+W.
  - Exactly one o_lcd_en pulse per accepted byte.
- o_lcd_data and o_lcd_rs hold their last value in IDLE. They change only on acceptance.
- A counter of at least clog2(max parameter) bits is reloaded on every state entry. No wrap-around is allowed.

Optional Feature:
- Macro: LCD_AUTO_INIT_EN.
- Defined: the 4-byte init sequence above runs after PWR_WAIT. o_init_done rises only after the last EXEC.
- Undefined: PWR_WAIT goes straight to IDLE with o_init_done = 1, and software must send the init commands itself. All other behaviour is identical.

Test Plan:
Bench overrides: PWR_WAIT_CYC=10, EN_CYC=3, CMD_WAIT_CYC=5, CLR_WAIT_CYC=20.
1. Macro off, release reset, idle inputs:
   - o_ready = 0 and o_init_done = 0 for 10 cycles, then both become 1.
   - o_lcd_on = 1 from the first post-reset cycle.
   - o_lcd_en never pulses.
2. Macro off, write rs=1 data=0x41, accepted at T:
   - o_lcd_data = 0x41 and o_lcd_rs = 1 from T+1.
   - o_lcd_en = 1 exactly in cycles T+3..T+5.
   - o_ready = 1 again at T+13.
3. Macro off, write rs=0 data=0x01: o_ready returns at T+28, using the clear wait.
   - Repeat with 0x02: same timing.
   - Repeat with 0x04: o_ready returns at T+13.
4. Hold i_valid high with data 0x42 right after an acceptance of 0x41:
   - One pulse carries 0x41; the next pulse carries 0x42, accepted only at T+13.
   - Exactly 2 o_lcd_en pulses total.
5. Macro on, release reset:
   - Exactly 4 o_lcd_en pulses carrying 0x38, 0x0C, 0x01, 0x06, with rs = 0.
   - o_init_done and o_ready rise together after the 0x06 EXEC.
   - i_valid asserted during init is ignored.
6. Assert i_rst_n = 0 during PULSE of a write:
   - Next edge: o_lcd_en = 0 and all outputs 0.
   - After release: a full 10-cycle PWR_WAIT repeats before o_ready = 1.
